button_debounce: RTL and testbench

//  Receive end of the push-button interface: takes the raw low-active board button (btnx,

---
 rtl/button_debounce_pkg.sv | 16 +
 rtl/button_debounce_sync_2ff.sv | 23 ++
 rtl/button_debounce.sv | 117 +++++++++++
 tb/tb_button_debounce.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// Shared types and board defaults for the push-button debouncer.
// FSM state encoding plus 24 MHz cycle constants used as parameter defaults.
package button_debounce_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   // 5 ms and 1 s at the 24 MHz board clock
   localparam int DEF_DEBOUNCE_CYCLES = 120_000;
   localparam int DEF_LONG_CYCLES     = 24_000_000;

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Single-bit two-flop synchronizer with a configurable reset value.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/button_debounce.sv
// Debounces the low-active board button into a level plus press/release/long strobes.
// Optional long-press detection is built when BTN_LONG_PRESS_EN is defined.
module button_debounce
   import button_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btnx,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int LW = $clog2(LONG_CYCLES);

   logic btn_sync;
   logic btn_s;
   btn_state_t state;
   logic [CW-1:0] cnt;

   // Raw pin goes straight into the synchronizer; released (high) is the reset level
   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btnx),
      .q   (btn_sync)
   );

   assign btn_s = ~btn_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         pressed       <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (btn_s) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!btn_s) begin
                  state <= IDLE;
               end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                  state       <= PRESSED;
                  pressed     <= 1'b1;
                  press_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (!btn_s) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
            end
            RELEASE_WAIT: begin
               // A high sample here is a bounce: return without any event
               if (btn_s) begin
                  state <= PRESSED;
               end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                  state         <= IDLE;
                  pressed       <= 1'b0;
                  release_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BTN_LONG_PRESS_EN
   logic [LW-1:0] lcnt;
   logic long_done;

   // lcnt saturates and is held through release bounces; only a pass through IDLE re-arms
   always_ff @(posedge clk) begin
      if (rst) begin
         lcnt       <= '0;
         long_done  <= 1'b0;
         long_pulse <= 1'b0;
      end else begin
         long_pulse <= 1'b0;
         if (state == IDLE || state == PRESS_WAIT) begin
            lcnt      <= '0;
            long_done <= 1'b0;
         end else if (state == PRESSED) begin
            if (lcnt == LW'(LONG_CYCLES - 1) && !long_done) begin
               long_pulse <= 1'b1;
               long_done  <= 1'b1;
            end
            if (btn_s && lcnt != LW'(LONG_CYCLES - 1)) begin
               lcnt <= lcnt + 1'b1;
            end
         end
      end
   end
`else
   assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with a run-length reference model.
// Honours BTN_LONG_PRESS_EN to decide whether long-press strobes are expected.
module tb_button_debounce;

   localparam int DC = 4;
   localparam int LC = 16;
`ifdef BTN_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btnx = 1'b0;
   logic pressed, press_pulse, release_pulse, long_pulse;

   int total = 0;
   int bad = 0;

   bit m_s1 = 1'b1, m_s2 = 1'b1;
   bit m_level = 1'b0;
   int m_run = 0;
   int m_hold = 0;
   bit m_fired = 1'b0;
   bit e_press = 1'b0, e_rel = 1'b0, e_long = 1'b0;

   button_debounce #(.DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC)) dut (
      .clk           (clk),
      .rst           (rst),
      .btnx          (btnx),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse)
   );

   always #5 clk = ~clk;

   // Reference: a level flips once DC+1 consecutive synchronized samples disagree with it
   always @(posedge clk) begin
      bit s;
      bit stable;
      e_press = 1'b0;
      e_rel   = 1'b0;
      e_long  = 1'b0;
      if (rst) begin
         m_s1 = 1'b1; m_s2 = 1'b1;
         m_level = 1'b0; m_run = 0; m_hold = 0; m_fired = 1'b0;
      end else begin
         s = ~m_s2;
         m_s2 = m_s1;
         m_s1 = btnx;
         stable = (m_run == 0);
         m_run = (s != m_level) ? m_run + 1 : 0;
         if (m_run == DC + 1) begin
            m_level = ~m_level;
            m_run = 0;
            if (m_level) begin
               e_press = 1'b1; m_hold = 0; m_fired = 1'b0;
            end else begin
               e_rel = 1'b1;
            end
         end else if (m_level && stable && LONG_EN) begin
            if (m_hold >= LC - 1 && !m_fired) begin
               e_long = 1'b1; m_fired = 1'b1;
            end
            if (s && m_hold < LC - 1) m_hold++;
         end
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      checkOutput("pressed_vs_model", int'(pressed), int'(m_level));
      checkOutput("press_pulse_vs_model", int'(press_pulse), int'(e_press));
      checkOutput("release_pulse_vs_model", int'(release_pulse), int'(e_rel));
      checkOutput("long_pulse_vs_model", int'(long_pulse), int'(e_long));
   end

   // Holds btnx for n edges; records first strobe edge (1-based) and strobe counts
   task automatic applyStimulus(input logic level, input int n,
                                output int pe, output int re, output int le,
                                output int np, output int nr, output int nl);
      pe = 0; re = 0; le = 0; np = 0; nr = 0; nl = 0;
      btnx = level;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (press_pulse === 1'b1) begin np++; if (pe == 0) pe = i; end
         if (release_pulse === 1'b1) begin nr++; if (re == 0) re = i; end
         if (long_pulse === 1'b1) begin nl++; if (le == 0) le = i; end
      end
   endtask

   initial begin
      int pe, re, le, np, nr, nl;
      int sp, sr;

      // Reset with button held, then requalify after rst drops
      rst = 1'b1; btnx = 1'b0;
      @(negedge clk); @(negedge clk);
      checkOutput("reset_pressed", int'(pressed), 0);
      checkOutput("reset_strobes", int'({press_pulse, release_pulse, long_pulse}), 0);
      rst = 1'b0;
      applyStimulus(1'b0, 40, pe, re, le, np, nr, nl);
      checkOutput("hold_press_edge", pe, 7);
      checkOutput("hold_press_count", np, 1);
      checkOutput("hold_release_count", nr, 0);
      checkOutput("hold_long_count", nl, LONG_EN ? 1 : 0);
      checkOutput("hold_long_edge", le, LONG_EN ? 23 : 0);
      checkOutput("hold_level", int'(pressed), 1);

      applyStimulus(1'b1, 10, pe, re, le, np, nr, nl);
      checkOutput("release_edge", re, 7);
      checkOutput("release_count", nr, 1);
      checkOutput("release_level", int'(pressed), 0);

      // Short low bursts never qualify
      sp = 0;
      applyStimulus(1'b0, 3, pe, re, le, np, nr, nl); sp += np;
      applyStimulus(1'b1, 1, pe, re, le, np, nr, nl); sp += np;
      applyStimulus(1'b0, 3, pe, re, le, np, nr, nl); sp += np;
      applyStimulus(1'b1, 10, pe, re, le, np, nr, nl); sp += np;
      checkOutput("bounce_press_count", sp, 0);
      checkOutput("bounce_level", int'(pressed), 0);

      // Release glitch of two cycles while pressed
      applyStimulus(1'b0, 10, pe, re, le, np, nr, nl);
      checkOutput("repress_edge", pe, 7);
      sr = 0; sp = 0;
      applyStimulus(1'b1, 2, pe, re, le, np, nr, nl); sr += nr; sp += np;
      applyStimulus(1'b0, 10, pe, re, le, np, nr, nl); sr += nr; sp += np;
      checkOutput("glitch_release_count", sr, 0);
      checkOutput("glitch_press_count", sp, 0);
      checkOutput("glitch_level", int'(pressed), 1);
      applyStimulus(1'b1, 10, pe, re, le, np, nr, nl);
      checkOutput("release2_edge", re, 7);

      // Reset while pressed: no release strobe, requalify afterwards
      applyStimulus(1'b0, 10, pe, re, le, np, nr, nl);
      checkOutput("pre_rst_press_edge", pe, 7);
      rst = 1'b1;
      applyStimulus(1'b0, 1, pe, re, le, np, nr, nl);
      checkOutput("rst_mid_level", int'(pressed), 0);
      checkOutput("rst_mid_release", nr, 0);
      rst = 1'b0;
      applyStimulus(1'b0, 10, pe, re, le, np, nr, nl);
      checkOutput("post_rst_press_edge", pe, 7);
      checkOutput("post_rst_press_count", np, 1);

      btnx = 1'b1;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
